// File: rtl/rule_scheduler.sv
// Rule-update sequencer for network_logic: owns the model state, issues rule indices per round.
// Optional build macro SCHED_HOLD_EN adds a `hold` input that stalls candidate selection.
module rule_scheduler #(
   parameter int                   STATE_W       = 61,
   parameter int                   NUM_RULES     = 38,
   parameter int                   RULE_W        = 6,
   parameter int                   ROUND_W       = 10,
   parameter logic [NUM_RULES-1:0] REG_RULE_MASK = 38'h0_0006_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 mode,
   input  logic [15:0]          seed,
   input  logic [ROUND_W-1:0]   num_rounds,
   input  logic [STATE_W-1:0]   init_state,
   input  logic [NUM_RULES-1:0] skip_mask,
   input  logic [STATE_W-1:0]   next_state,
`ifdef SCHED_HOLD_EN
   input  logic                 hold,
`endif
   output logic [STATE_W-1:0]   current_state,
   output logic [RULE_W-1:0]    rule,
   output logic [ROUND_W-1:0]   round_number,
   output logic                 busy,
   output logic                 round_valid,
   output logic                 done
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_PICK      = 3'd2;
   localparam logic [2:0] S_APPLY     = 3'd3;
   localparam logic [2:0] S_WAIT      = 3'd4;
   localparam logic [2:0] S_ROUND_END = 3'd5;
   localparam logic [2:0] S_DONE      = 3'd6;

   localparam int               IDX_N        = 1 << RULE_W;
   localparam int               PAD          = IDX_N - NUM_RULES;
   localparam logic [RULE_W-1:0] RULE_IDLE   = '1;
   localparam logic [15:0]      LFSR_DEFAULT = 16'hACE1;
   localparam logic [15:0]      LFSR_TAPS    = 16'hB400;
   localparam logic [IDX_N-1:0] REG_EXT      = {{PAD{1'b0}}, REG_RULE_MASK};

   logic [2:0]           state_reg;
   logic [RULE_W-1:0]    cand_reg;
   logic [NUM_RULES-1:0] used_reg;
   logic [15:0]          lfsr_reg;
   logic                 mode_reg;
   logic [ROUND_W-1:0]   rounds_reg;

   logic [IDX_N-1:0]     used_ext;
   logic [IDX_N-1:0]     skip_ext;
   logic [NUM_RULES-1:0] used_next;
   logic [15:0]          lfsr_next;
   logic [RULE_W-1:0]    cand_init;
   logic [RULE_W-1:0]    cand_adv;
   logic [15:0]          lfsr_adv;
   logic [ROUND_W-1:0]   round_inc;
   logic                 stall;

`ifdef SCHED_HOLD_EN
   assign stall = hold;
`else
   assign stall = 1'b0;
`endif

   // Indices past NUM_RULES read as already used so the candidate walks over them.
   assign used_ext  = {{PAD{1'b1}}, used_reg};
   assign skip_ext  = {{PAD{1'b0}}, skip_mask};
   assign used_next = used_reg | (NUM_RULES'(1) << cand_reg);
   assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);
   assign cand_init = mode_reg ? lfsr_reg[RULE_W-1:0] : '0;
   assign cand_adv  = mode_reg ? lfsr_next[RULE_W-1:0] : rule + 1'b1;
   assign lfsr_adv  = mode_reg ? lfsr_next : lfsr_reg;
   assign round_inc = round_number + 1'b1;

   assign busy        = (state_reg != S_IDLE) && (state_reg != S_DONE);
   assign round_valid = (state_reg == S_ROUND_END);
   assign done        = (state_reg == S_DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         current_state <= '0;
         round_number  <= '0;
         rule          <= RULE_IDLE;
         lfsr_reg      <= LFSR_DEFAULT;
         used_reg      <= '0;
         cand_reg      <= '0;
         mode_reg      <= 1'b0;
         rounds_reg    <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  current_state <= init_state;
                  round_number  <= '0;
                  used_reg      <= '0;
                  mode_reg      <= mode;
                  rounds_reg    <= num_rounds;
                  lfsr_reg      <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
                  state_reg     <= S_LOAD;
               end
            end
            S_LOAD: begin
               cand_reg  <= cand_init;
               state_reg <= (rounds_reg == '0) ? S_DONE : S_PICK;
            end
            S_PICK: begin
               if (!stall) begin
                  if (&used_reg) begin
                     state_reg <= S_ROUND_END;
                  end else if (used_ext[cand_reg]) begin
                     cand_reg <= cand_reg + 1'b1;
                  end else if (skip_ext[cand_reg]) begin
                     used_reg <= used_next;
                     cand_reg <= cand_reg + 1'b1;
                  end else begin
                     rule      <= cand_reg;
                     used_reg  <= used_next;
                     state_reg <= S_APPLY;
                  end
               end
            end
            S_APPLY, S_WAIT: begin
               // Registered datapath rules need one more cycle before next_state is valid.
               if (state_reg == S_APPLY && REG_EXT[rule]) begin
                  state_reg <= S_WAIT;
               end else begin
                  current_state <= next_state;
                  cand_reg      <= cand_adv;
                  lfsr_reg      <= lfsr_adv;
                  rule          <= RULE_IDLE;
                  state_reg     <= S_PICK;
               end
            end
            S_ROUND_END: begin
               round_number <= round_inc;
               used_reg     <= '0;
               cand_reg     <= cand_init;
               state_reg    <= (round_inc == rounds_reg) ? S_DONE : S_PICK;
            end
            S_DONE: begin
               state_reg <= S_IDLE;
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rule_scheduler.sv
// Directed self-checking bench for rule_scheduler (define SCHED_HOLD_EN to exercise hold).
`timescale 1ns/1ps
module tb_rule_scheduler;

   localparam logic [60:0] INIT_A = 61'h0123_4567_89AB_CDEF;
   localparam logic [60:0] INIT_B = 61'h1555_0000_FFFF_1234;
   localparam logic [60:0] INIT_C = 61'h0F0F_F0F0_1357_9BDF;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] seed = 16'h0;
   logic [9:0]  num_rounds = 10'd0;
   logic [60:0] init_state = 61'h0;
   logic [37:0] skip_mask = 38'h0;
   logic [60:0] next_state;
   logic [60:0] current_state;
   logic [5:0]  rule;
   logic [9:0]  round_number;
   logic        busy;
   logic        round_valid;
   logic        done;
   logic        hold_drv = 1'b0;

   int tests = 0;
   int fails = 0;
   int issued[$];
   int rv_steps[$];
   int rand1[$];
   int done_step;
   int hold_bad;

   always #5 clk = ~clk;

   function automatic logic [60:0] rule_fn(input logic [60:0] cs, input logic [5:0] r);
      return {cs[59:0], cs[60]} ^ {55'd0, r};
   endfunction

   assign next_state = rule_fn(current_state, rule);

   rule_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .mode          (mode),
      .seed          (seed),
      .num_rounds    (num_rounds),
      .init_state    (init_state),
      .skip_mask     (skip_mask),
      .next_state    (next_state),
`ifdef SCHED_HOLD_EN
      .hold          (hold_drv),
`endif
      .current_state (current_state),
      .rule          (rule),
      .round_number  (round_number),
      .busy          (busy),
      .round_valid   (round_valid),
      .done          (done)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sequential full-round model: every rule applied once in index order.
   function automatic logic [60:0] seq_model(input logic [60:0] init);
      logic [60:0] s;
      s = init;
      for (int r = 0; r < 38; r++) s = rule_fn(s, 6'(r));
      return s;
   endfunction

   // One run from start to done; records issued rules and the step of each round_valid/done.
   task automatic run(input logic [9:0] nr, input logic md, input logic [15:0] sd,
                      input logic [37:0] sk, input logic [60:0] init,
                      input int hold_at, input int hold_len);
      int prev;
      issued.delete();
      rv_steps.delete();
      done_step = -1;
      hold_bad = 0;
      num_rounds = nr;
      mode = md;
      seed = sd;
      skip_mask = sk;
      init_state = init;
      start = 1'b1;
      step();
      start = 1'b0;
      check("load_busy", {63'd0, busy}, 64'd1);
      prev = 63;
      for (int s = 1; s <= 6000; s++) begin
         if (s == hold_at) hold_drv = 1'b1;
         if (s == hold_at + hold_len) hold_drv = 1'b0;
         step();
         if (hold_drv && rule != 6'd63) hold_bad++;
         if (rule != 6'd63 && prev == 63) issued.push_back(int'(rule));
         prev = int'(rule);
         if (round_valid) rv_steps.push_back(s);
         if (done) begin
            done_step = s;
            break;
         end
      end
      hold_drv = 1'b0;
      check("run_terminated", (done_step >= 0) ? 64'd1 : 64'd0, 64'd1);
   endtask

   initial begin
      logic [60:0] exp_seq;
      logic [60:0] s_model;
      logic [37:0] seen;
      int diff;
      int found;

      // Reset values
      rst_n = 1'b0;
      step();
      step();
      check("rst_current_state", 64'(current_state), 64'd0);
      check("rst_rule", 64'(rule), 64'd63);
      check("rst_round_number", 64'(round_number), 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_round_valid", {63'd0, round_valid}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      rst_n = 1'b1;
      step();

      // Sequential, one round, nothing skipped
      exp_seq = seq_model(INIT_A);
      run(10'd1, 1'b0, 16'h0, 38'h0, INIT_A, -1, 0);
      check("seq_issue_count", 64'(issued.size()), 64'd38);
      for (int i = 0; i < 38; i++) check($sformatf("seq_rule_%0d", i), 64'(issued[i]), 64'(i));
      check("seq_rv_count", 64'(rv_steps.size()), 64'd1);
      check("seq_rv_step", 64'((rv_steps.size() > 0) ? rv_steps[0] : -1), 64'd80);
      check("seq_done_step", 64'(done_step), 64'd81);
      check("seq_done_busy", {63'd0, busy}, 64'd0);
      check("seq_round_number", 64'(round_number), 64'd1);
      check("seq_state", 64'(current_state), 64'(exp_seq));
      step();
      check("seq_idle_done", {63'd0, done}, 64'd0);
      check("seq_idle_rule", 64'(rule), 64'd63);

      // Random permutation, seed 0 -> ACE1: first cand 0x21=33, then lfsr E270 -> 48, wraps to 0
      run(10'd2, 1'b1, 16'h0, 38'h0, INIT_B, -1, 0);
      check("rnd_issue_count", 64'(issued.size()), 64'd76);
      check("rnd_first_rule", 64'(issued[0]), 64'd33);
      check("rnd_second_rule", 64'(issued[1]), 64'd0);
      for (int r = 0; r < 2; r++) begin
         seen = '0;
         for (int i = 0; i < 38; i++) seen[issued[r*38 + i]] = 1'b1;
         check($sformatf("rnd_round%0d_distinct", r + 1), 64'(seen), 64'h3F_FFFF_FFFF);
      end
      diff = 0;
      for (int i = 0; i < 38; i++) if (issued[i] != issued[38 + i]) diff++;
      check("rnd_rounds_differ", (diff != 0) ? 64'd1 : 64'd0, 64'd1);
      check("rnd_rv_count", 64'(rv_steps.size()), 64'd2);
      check("rnd_round_number", 64'(round_number), 64'd2);
      s_model = INIT_B;
      foreach (issued[i]) s_model = rule_fn(s_model, 6'(issued[i]));
      check("rnd_state", 64'(current_state), 64'(s_model));
      rand1 = issued;
      step();

      // Same seed again reproduces the sequence
      run(10'd2, 1'b1, 16'h0, 38'h0, INIT_B, -1, 0);
      diff = 0;
      for (int i = 0; i < 76; i++) if (issued[i] != rand1[i]) diff++;
      check("rnd_rerun_count", 64'(issued.size()), 64'd76);
      check("rnd_rerun_same", 64'(diff), 64'd0);
      step();

      // Every rule skipped, three rounds
      run(10'd3, 1'b0, 16'h0, 38'h3F_FFFF_FFFF, INIT_C, -1, 0);
      check("skip_issue_count", 64'(issued.size()), 64'd0);
      check("skip_rv_count", 64'(rv_steps.size()), 64'd3);
      check("skip_rv1_step", 64'((rv_steps.size() > 0) ? rv_steps[0] : -1), 64'd40);
      check("skip_done_step", 64'(done_step), 64'd121);
      check("skip_round_number", 64'(round_number), 64'd3);
      check("skip_state", 64'(current_state), 64'(INIT_C));
      step();

      // Zero rounds: LOAD then DONE
      num_rounds = 10'd0;
      mode = 1'b0;
      skip_mask = 38'h0;
      init_state = INIT_A;
      start = 1'b1;
      step();
      start = 1'b0;
      check("zero_load_busy", {63'd0, busy}, 64'd1);
      check("zero_load_done", {63'd0, done}, 64'd0);
      step();
      check("zero_done", {63'd0, done}, 64'd1);
      check("zero_round_number", 64'(round_number), 64'd0);
      check("zero_rule", 64'(rule), 64'd63);
      check("zero_state", 64'(current_state), 64'(INIT_A));
      step();
      check("zero_done_clear", {63'd0, done}, 64'd0);

      // Reset during an APPLY of round 2
      num_rounds = 10'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      diff = 0;
      found = 0;
      for (int s = 0; s < 400; s++) begin
         step();
         if (round_valid) diff++;
         if (diff >= 1 && rule != 6'd63) begin
            found = 1;
            break;
         end
      end
      check("midrst_reached_apply", 64'(found), 64'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("midrst_busy", {63'd0, busy}, 64'd0);
      check("midrst_rule", 64'(rule), 64'd63);
      check("midrst_state", 64'(current_state), 64'd0);
      check("midrst_round_number", 64'(round_number), 64'd0);
      step();
      run(10'd1, 1'b0, 16'h0, 38'h0, INIT_A, -1, 0);
      check("midrst_rerun_rv_step", 64'((rv_steps.size() > 0) ? rv_steps[0] : -1), 64'd80);
      check("midrst_rerun_state", 64'(current_state), 64'(exp_seq));
      check("midrst_rerun_round_number", 64'(round_number), 64'd1);
      step();

`ifdef SCHED_HOLD_EN
      // Hold for 10 cycles while in PICK (sample 21 is the PICK before rule 10)
      run(10'd1, 1'b0, 16'h0, 38'h0, INIT_A, 22, 10);
      check("hold_issue_count", 64'(issued.size()), 64'd38);
      for (int i = 0; i < 38; i++) check($sformatf("hold_rule_%0d", i), 64'(issued[i]), 64'(i));
      check("hold_rule_idle", 64'(hold_bad), 64'd0);
      check("hold_rv_step", 64'((rv_steps.size() > 0) ? rv_steps[0] : -1), 64'd90);
      check("hold_done_step", 64'(done_step), 64'd91);
      check("hold_state", 64'(current_state), 64'(exp_seq));
      step();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rule_scheduler.md
Name: rule_scheduler

Overview:
- Sequencing controller for the network_logic rule-update datapath.
- Owns the model state register and drives `current_state`, `rule` and `round_number`. Captures `next_state` after each rule application.
- Runs a programmable number of rounds. Each round applies every enabled rule exactly once, either in index order or in an LFSR-driven random permutation (asynchronous-update simulation).

Parameters:
- STATE_W, 61, width of the model state vector.
- NUM_RULES, 38, number of rule indices (0..NUM_RULES-1); must be < 2**RULE_W - 1.
- RULE_W, 6, width of the rule index.
- ROUND_W, 10, width of round counters.
- REG_RULE_MASK, 38'h0_0006_0000 (bits 17,18), rules whose datapath update is registered; these need one extra settle cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- mode  in  1  0 = sequential order, 1 = random permutation; sampled at start.
- seed  in  16  LFSR seed, sampled at start; 0 is replaced by 16'hACE1.
- num_rounds  in  ROUND_W  rounds to run, sampled at start.
- init_state  in  STATE_W  initial model state, loaded at start.
- skip_mask  in  NUM_RULES  1 = rule disabled; sampled live in PICK.
- next_state  in  STATE_W  from network_logic.
- current_state  out  STATE_W  state register to network_logic.
- rule  out  RULE_W  rule index to network_logic.
- round_number  out  ROUND_W  completed-round count.
- busy  out  1  high from LOAD through ROUND_END.
- round_valid  out  1  1-cycle pulse per completed round.
- done  out  1  1-cycle pulse at run end.

Behaviour:
- Reset values: state IDLE; current_state=0; round_number=0; rule=RULE_IDLE (all ones, a no-op index); busy=0; round_valid=0; done=0; lfsr=16'hACE1; used=0.
- `rule` = RULE_IDLE in every state except APPLY/WAIT.
- FSM states: IDLE, LOAD, PICK, APPLY, WAIT, ROUND_END, DONE.
- IDLE:
  - start=1 → current_state<=init_state, round_number<=0, used<=0, latch mode/num_rounds/seed; go to LOAD.
  - start while not IDLE is ignored.
- LOAD:
  - cand<=0 (sequential) or lfsr[RULE_W-1:0] (random).
  - If num_rounds==0, go to DONE; else go to PICK.
- PICK, one candidate examined per cycle, checked in priority order:
  1. All NUM_RULES bits of `used` set → ROUND_END.
  2. cand>=NUM_RULES or used[cand] → cand<=cand+1 (mod 2**RULE_W); stay.
  3. skip_mask[cand] → used[cand]<=1, cand+1; stay.
  4. Otherwise → rule<=cand, used[cand]<=1, go to APPLY.
- APPLY:
  - If REG_RULE_MASK[rule] is set, go to WAIT.
  - Otherwise current_state<=next_state, advance, go to PICK.
- WAIT: `rule` is held; current_state<=next_state, advance, go to PICK.
- Advance:
  - Sequential: cand<=rule+1.
  - Random: lfsr<=lfsr_next, cand<=lfsr_next[RULE_W-1:0].
  - LFSR is a 16-bit Galois, shift right, taps 16'hB400.
- ROUND_END:
  - round_valid=1, round_number<=round_number+1, used<=0.
  - cand re-initialised as in LOAD.
  - If round_number+1==num_rounds, go to DONE; else go to PICK.
- DONE: done=1 for one cycle, busy=0, go to IDLE. current_state and round_number hold until the next start.
- Timing: non-registered rule = 2 cycles (PICK+APPLY) when the candidate hits on the first try; registered rule = 3 cycles.
- round_number wraps modulo 2**ROUND_W; num_rounds is never exceeded.
- All-rules-skipped round: NUM_RULES skip cycles, then ROUND_END; current_state unchanged.
- rst_n low mid-run: all reset values on the next edge; in-flight rule is discarded.

Optional Feature:
- Macro SCHED_HOLD_EN.
- Defined:
  - Adds input `hold` (1 bit).
  - While hold=1 in PICK, FSM, cand, lfsr and used are frozen and rule=RULE_IDLE.
  - hold has no effect in other states, so APPLY/WAIT always complete.
- Undefined: no port; PICK never stalls.

Test Plan:
- Sequential, num_rounds=1, skip_mask=0:
  - rule sequence 0,1,…,37 with 17 and 18 each held 2 cycles.
  - round_valid at cycle 79 after LOAD (80 cycles incl. ROUND_END); done next cycle; round_number=1.
- Random, seed=0 → lfsr loads 16'hACE1:
  - each round issues 38 distinct indices; permutation differs between rounds 1 and 2.
  - Same seed rerun gives an identical sequence.
- skip_mask=all ones, num_rounds=3: rule stays 63 throughout, current_state==init_state, three round_valid pulses, round_number=3.
- num_rounds=0: done pulses 2 cycles after start; no rule issued; round_number=0.
- rst_n low during round 2 APPLY: next cycle IDLE, current_state=0, rule=63, busy=0; a fresh start runs normally.
- With SCHED_HOLD_EN, hold=1 for 10 cycles mid-round: rule=63 during hold; issued sequence identical to the no-hold run, delayed exactly 10 cycles.
